remote_comm_mb: RTL and testbench

//  Parametrised successor to the two-byte remote command sender. Sends a CMD_BYTES-wide command
//  MSB-byte first over the existing UART block. Optionally waits for a one-byte response, with a

---
 rtl/remote_comm_mb.sv | 399 +++++++++++++++++++++++++++++++++++++++
 tb/tb_remote_comm_mb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/remote_comm_mb.sv
`default_nettype none
// ============================================================================
// Module      : remote_comm_mb (+ remote_comm_mb_uart_tx, remote_comm_mb_uart_rx)
// Description : Multi-byte remote command sender. Sends a CMD_BYTES-wide
//               command MSB-byte first over an 8N1 UART, optionally waits for
//               a one-byte response with timeout and bounded resend count.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// 8N1 UART transmitter. tx_done rises at the end of the stop bit and is
// cleared by the next trmt, so a waiting master never sees a stale done.
// ----------------------------------------------------------------------------
module remote_comm_mb_uart_tx #(
    parameter int BAUD_DIV = 434            // clocks per bit, >= 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_trmt,
    input  logic [7:0] i_tx_data,
    output logic       o_tx,
    output logic       o_tx_done
);
    localparam int c_BW = $clog2(BAUD_DIV);
    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(BAUD_DIV - 1);

    logic            r_busy;
    logic [c_BW-1:0] r_baud;
    logic [3:0]      r_bit;
    logic [8:0]      r_shift;
    logic            r_tx;
    logic            r_done;

    // Frame sequencer: start bit on trmt, then 8 data bits LSB first, then stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_baud  <= '0;
            r_bit   <= 4'd0;
            r_shift <= 9'h1FF;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else if (i_trmt) begin
            r_busy  <= 1'b1;
            r_baud  <= '0;
            r_bit   <= 4'd0;
            r_shift <= {1'b1, i_tx_data};
            r_tx    <= 1'b0;
            r_done  <= 1'b0;
        end else if (r_busy) begin
            if (r_baud == c_BAUD_LAST) begin
                r_baud <= '0;
                if (r_bit == 4'd9) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b1, r_shift[8:1]};
                    r_bit   <= r_bit + 4'd1;
                end
            end else begin
                r_baud <= r_baud + c_BW'(1);
            end
        end
    end

    assign o_tx      = r_tx;
    assign o_tx_done = r_done;
endmodule

// ----------------------------------------------------------------------------
// 8N1 UART receiver with two-flop input synchroniser. rx_rdy is held until
// clr_rx_rdy; a new byte arriving in the same cycle as the clear wins.
// ----------------------------------------------------------------------------
module remote_comm_mb_uart_rx #(
    parameter int BAUD_DIV = 434            // clocks per bit, >= 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    input  logic       i_clr_rx_rdy,
    output logic       o_rx_rdy,
    output logic [7:0] o_rx_data
);
    localparam int c_BW = $clog2(BAUD_DIV);
    localparam logic [c_BW-1:0] c_FULL_LAST = c_BW'(BAUD_DIV - 1);
    localparam logic [c_BW-1:0] c_HALF_LAST = c_BW'(BAUD_DIV / 2 - 1);

    logic            r_s1;
    logic            r_s2;
    logic            r_busy;
    logic [c_BW-1:0] r_baud;
    logic [3:0]      r_bit;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_rdy;
    logic            w_tick;
    logic            w_done;

    // Start bit is timed to its middle, every later bit a full period on
    assign w_tick = r_busy && (r_baud == ((r_bit == 4'd0) ? c_HALF_LAST : c_FULL_LAST));
    assign w_done = w_tick && (r_bit == 4'd9);

    // Metastability guard on the asynchronous serial input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_rx;
            r_s2 <= r_s1;
        end
    end

    // Frame sampler; a start bit that is high again at mid-bit is a glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_baud  <= '0;
            r_bit   <= 4'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
        end else if (!r_busy) begin
            if (!r_s2) begin
                r_busy <= 1'b1;
                r_baud <= '0;
                r_bit  <= 4'd0;
            end
        end else if (w_tick) begin
            r_baud <= '0;
            if (r_bit == 4'd0) begin
                if (r_s2) begin
                    r_busy <= 1'b0;
                end else begin
                    r_bit <= 4'd1;
                end
            end else if (r_bit == 4'd9) begin
                r_busy <= 1'b0;
                r_data <= r_shift;
            end else begin
                r_shift <= {r_s2, r_shift[7:1]};
                r_bit   <= r_bit + 4'd1;
            end
        end else begin
            r_baud <= r_baud + c_BW'(1);
        end
    end

    // Ready flag: set has priority over clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy <= 1'b0;
        end else if (w_done) begin
            r_rdy <= 1'b1;
        end else if (i_clr_rx_rdy) begin
            r_rdy <= 1'b0;
        end
    end

    assign o_rx_rdy  = r_rdy;
    assign o_rx_data = r_data;
endmodule

// ----------------------------------------------------------------------------
// Command sender top level
// ----------------------------------------------------------------------------
module remote_comm_mb #(
    parameter int         CMD_BYTES   = 2,
    parameter int         WAIT_RESP   = 1,
    parameter logic [7:0] ACK_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CYC = 1000000,
    parameter int         MAX_RETRY   = 2,
    parameter int         BAUD_DIV    = 434
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   snd_cmd,
    input  logic [8*CMD_BYTES-1:0] cmd,
    input  logic                   RX,
    output logic                   TX,
    output logic                   busy,
    output logic                   cmd_snt,
    output logic                   resp_rdy,
    output logic [7:0]             resp,
    input  logic                   clr_resp_rdy,
    output logic                   ack_ok,
    output logic                   err_timeout
);
    localparam int c_IDX_W = $clog2(CMD_BYTES) + 1;
    localparam int c_TMR_W = $clog2(TIMEOUT_CYC);
    localparam int c_RTY_W = $clog2(MAX_RETRY + 1) + 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(CMD_BYTES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [c_RTY_W-1:0] c_RTY_MAX  = c_RTY_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_TX = 2'd2,
        ST_WAIT_RX = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_nxt_state;
    logic [8*CMD_BYTES-1:0] r_cmd;
    logic [c_IDX_W-1:0]     r_byte_idx;
    logic [c_TMR_W-1:0]     r_timer;
    logic [c_RTY_W-1:0]     r_retry;
    logic                   r_cmd_snt;
    logic                   r_resp_rdy;
    logic [7:0]             r_resp;
    logic                   r_ack;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_trmt;
    logic                   w_byte_inc;
    logic                   w_last_done;
    logic                   w_got_resp;
    logic                   w_resend;
    logic                   w_fail;
    logic                   w_tmr_inc;
    logic [7:0]             w_tx_byte;
    logic                   w_tx_done;
    logic                   w_rx_rdy;
    logic [7:0]             w_rx_data;

    remote_comm_mb_uart_tx #(.BAUD_DIV(BAUD_DIV)) u_uart_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_trmt    (w_trmt),
        .i_tx_data (w_tx_byte),
        .o_tx      (TX),
        .o_tx_done (w_tx_done)
    );

    // Any received byte is acknowledged at once; only WAIT_RX keeps it
    remote_comm_mb_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_uart_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rx         (RX),
        .i_clr_rx_rdy (w_rx_rdy),
        .o_rx_rdy     (w_rx_rdy),
        .o_rx_data    (w_rx_data)
    );

    // Byte selector: index 0 is the most significant byte of the captured word
    always_comb begin
        w_tx_byte = 8'h00;
        for (int i = 0; i < CMD_BYTES; i++) begin
            if (r_byte_idx == c_IDX_W'(CMD_BYTES - 1 - i)) begin
                w_tx_byte = r_cmd[8*i +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next-state and control strobes; response beats timeout in one cycle
    always_comb begin
        w_nxt_state = r_state;
        w_accept    = 1'b0;
        w_trmt      = 1'b0;
        w_byte_inc  = 1'b0;
        w_last_done = 1'b0;
        w_got_resp  = 1'b0;
        w_resend    = 1'b0;
        w_fail      = 1'b0;
        w_tmr_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (snd_cmd) begin
                    w_accept    = 1'b1;
                    w_nxt_state = ST_SEND;
                end
            end
            ST_SEND: begin
                w_trmt      = 1'b1;
                w_nxt_state = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (w_tx_done) begin
                    if (r_byte_idx == c_LAST_IDX) begin
                        w_last_done = 1'b1;
                        w_nxt_state = (WAIT_RESP != 0) ? ST_WAIT_RX : ST_IDLE;
                    end else begin
                        w_byte_inc  = 1'b1;
                        w_nxt_state = ST_SEND;
                    end
                end
            end
            ST_WAIT_RX: begin
                if (w_rx_rdy) begin
                    w_got_resp  = 1'b1;
                    w_nxt_state = ST_IDLE;
                end else if (r_timer == c_TMR_LAST) begin
                    if (r_retry < c_RTY_MAX) begin
                        w_resend    = 1'b1;
                        w_nxt_state = ST_SEND;
                    end else begin
                        w_fail      = 1'b1;
                        w_nxt_state = ST_IDLE;
                    end
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // Captured command word; resends always reuse this copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd <= '0;
        end else if (w_accept) begin
            r_cmd <= cmd;
        end
    end

    // Byte, retry and response-timer counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_idx <= '0;
            r_retry    <= '0;
            r_timer    <= '0;
        end else begin
            if (w_accept) begin
                r_byte_idx <= '0;
                r_retry    <= '0;
            end else if (w_resend) begin
                r_byte_idx <= '0;
                r_retry    <= r_retry + c_RTY_W'(1);
            end else if (w_byte_inc) begin
                r_byte_idx <= r_byte_idx + c_IDX_W'(1);
            end
            if (w_last_done) begin
                r_timer <= '0;
            end else if (w_tmr_inc) begin
                r_timer <= r_timer + c_TMR_W'(1);
            end
        end
    end

    // Status flags: cmd_snt per attempt, err_timeout after the final attempt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_snt <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept || w_resend) begin
                r_cmd_snt <= 1'b0;
            end else if (w_last_done) begin
                r_cmd_snt <= 1'b1;
            end
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_fail) begin
                r_err <= 1'b1;
            end
        end
    end

    // Response capture; a new response wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp     <= 8'h00;
            r_ack      <= 1'b0;
            r_resp_rdy <= 1'b0;
        end else if (w_got_resp) begin
            r_resp     <= w_rx_data;
            r_ack      <= (w_rx_data == ACK_BYTE);
            r_resp_rdy <= 1'b1;
        end else if (w_accept) begin
            r_ack      <= 1'b0;
            r_resp_rdy <= 1'b0;
        end else if (clr_resp_rdy) begin
            r_resp_rdy <= 1'b0;
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign cmd_snt     = r_cmd_snt;
    assign resp_rdy    = r_resp_rdy;
    assign resp        = r_resp;
    assign ack_ok      = r_ack & r_resp_rdy;
    assign err_timeout = r_err;
endmodule

`default_nettype wire

// File: tb/tb_remote_comm_mb.sv
`default_nettype none
// ============================================================================
// Module      : tb_remote_comm_mb
// Description : Self-checking bench for remote_comm_mb. A decodes serial TX
//               into byte queues and compares against command bytes derived
//               arithmetically from the word, with a serial remote responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_remote_comm_mb;
    localparam int D = 8;   // clocks per UART bit

    logic        clk;
    logic        rst_n;
    logic        a_snd, a_rx, a_tx, a_busy, a_snt, a_rrdy, a_clr, a_ack, a_err;
    logic [15:0] a_cmd;
    logic [7:0]  a_resp;
    logic        b_snd, b_rx, b_tx, b_busy, b_snt, b_rrdy, b_clr, b_ack, b_err;
    logic [31:0] b_cmd;
    logic [7:0]  b_resp;

    int          n_checks;
    int          n_errors;
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [7:0]  exp_resp;

    remote_comm_mb #(.CMD_BYTES(2), .WAIT_RESP(0), .ACK_BYTE(8'hA5),
                     .TIMEOUT_CYC(100), .MAX_RETRY(2), .BAUD_DIV(D)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .snd_cmd(a_snd), .cmd(a_cmd), .RX(a_rx), .TX(a_tx),
        .busy(a_busy), .cmd_snt(a_snt), .resp_rdy(a_rrdy), .resp(a_resp),
        .clr_resp_rdy(a_clr), .ack_ok(a_ack), .err_timeout(a_err));

    remote_comm_mb #(.CMD_BYTES(4), .WAIT_RESP(1), .ACK_BYTE(8'hA5),
                     .TIMEOUT_CYC(100), .MAX_RETRY(2), .BAUD_DIV(D)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .snd_cmd(b_snd), .cmd(b_cmd), .RX(b_rx), .TX(b_tx),
        .busy(b_busy), .cmd_snt(b_snt), .resp_rdy(b_rrdy), .resp(b_resp),
        .clr_resp_rdy(b_clr), .ack_ok(b_ack), .err_timeout(b_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serial decoders: detect start bit, sample each bit at its middle
    initial begin : mon_a
        logic [7:0] mb;
        forever begin
            @(negedge clk);
            if (a_tx === 1'b0) begin
                repeat (D/2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (D) @(negedge clk);
                    mb[i] = a_tx;
                end
                repeat (D) @(negedge clk);
                qa.push_back(mb);
            end
        end
    end

    initial begin : mon_b
        logic [7:0] mb;
        forever begin
            @(negedge clk);
            if (b_tx === 1'b0) begin
                repeat (D/2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (D) @(negedge clk);
                    mb[i] = b_tx;
                end
                repeat (D) @(negedge clk);
                qb.push_back(mb);
            end
        end
    end

    // Remote end: one 8N1 frame on the selected RX line
    task automatic drive_rx(input bit which, input logic [7:0] v);
        logic [9:0] fr;
        fr = {1'b1, v, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (which) b_rx = fr[i]; else a_rx = fr[i];
            repeat (D) @(negedge clk);
        end
    endtask

    task automatic wait_idle(input bit which, input int budget, input string tag);
        int n;
        n = 0;
        while ((which ? b_busy : a_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, which ? b_busy : a_busy, 1'b0);
    endtask

    // Two-byte sender without response: latency, busy/cmd_snt timing, bytes
    task automatic run_a(input logic [15:0] c);
        int  n;
        bit  seen;
        logic pb;
        qa.delete();
        @(negedge clk); a_cmd = c; a_snd = 1'b1;
        @(negedge clk); a_snd = 1'b0;
        chk("A_busy_start", a_busy, 1'b1);
        chk("A_tx_before_trmt", a_tx, 1'b1);
        @(negedge clk);
        chk("A_first_start_bit", a_tx, 1'b0);
        n = 0; seen = 0; pb = 1'b0;
        while (!seen && n < 1000) begin
            @(negedge clk);
            n++;
            if (a_snt) seen = 1; else pb = a_busy;
        end
        chk("A_snt_seen", seen, 1'b1);
        chk("A_busy_at_snt", a_busy, 1'b0);
        chk("A_busy_before_snt", pb, 1'b1);
        repeat (4) @(negedge clk);
        chk("A_nframes", qa.size(), 2);
        for (int i = 0; i < 2 && i < qa.size(); i++)
            chk($sformatf("A_byte%0d", i), qa[i], (c >> (8 * (1 - i))) & 16'hFF);
    endtask

    // mode 0: ACK response, 1: given response byte, 2: silent remote
    task automatic run_b(input logic [31:0] c, input int mode, input logic [7:0] rv, input bit disturb);
        int n;
        int natt;
        natt = (mode == 2) ? 3 : 1;
        qb.delete();
        @(negedge clk); b_cmd = c; b_snd = 1'b1;
        @(negedge clk); b_snd = 1'b0;
        chk("B_busy_start", b_busy, 1'b1);
        chk("B_snt_clr", b_snt, 1'b0);
        chk("B_rrdy_clr", b_rrdy, 1'b0);
        chk("B_err_clr", b_err, 1'b0);
        if (disturb) begin
            repeat (20) @(negedge clk);
            b_cmd = ~c; b_snd = 1'b1;
            @(negedge clk); b_snd = 1'b0;
        end
        if (mode != 2) begin
            n = 0;
            while (!b_snt && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk("B_snt_wait", b_snt, 1'b1);
            drive_rx(1'b1, rv);
        end
        wait_idle(1'b1, 4000, "B");
        repeat (4) @(negedge clk);
        chk("B_nframes", qb.size(), 4 * natt);
        for (int i = 0; i < 4 * natt && i < qb.size(); i++)
            chk($sformatf("B_byte%0d", i), qb[i], (c >> (8 * (3 - (i % 4)))) & 32'hFF);
        if (mode != 2) exp_resp = rv;
        chk("B_resp", b_resp, exp_resp);
        chk("B_resp_rdy", b_rrdy, mode != 2);
        chk("B_ack_ok", b_ack, (mode != 2) && (rv == 8'hA5));
        chk("B_err_timeout", b_err, mode == 2);
        chk("B_cmd_snt", b_snt, 1'b1);
    endtask

    task automatic clr_b();
        @(negedge clk); b_clr = 1'b1;
        @(negedge clk); b_clr = 1'b0;
        chk("B_rrdy_after_clr", b_rrdy, 1'b0);
        chk("B_ack_after_clr", b_ack, 1'b0);
        chk("B_resp_after_clr", b_resp, exp_resp);
    endtask

    task automatic chk_reset_vals();
        chk("R_a_tx", a_tx, 1'b1);
        chk("R_a_busy", a_busy, 1'b0);
        chk("R_b_tx", b_tx, 1'b1);
        chk("R_b_busy", b_busy, 1'b0);
        chk("R_b_snt", b_snt, 1'b0);
        chk("R_b_rrdy", b_rrdy, 1'b0);
        chk("R_b_resp", b_resp, 8'h00);
        chk("R_b_ack", b_ack, 1'b0);
        chk("R_b_err", b_err, 1'b0);
    endtask

    initial begin
        int mode;
        logic [7:0] rv;
        n_checks = 0; n_errors = 0; exp_resp = 8'h00;
        a_snd = 0; a_cmd = '0; a_rx = 1; a_clr = 0;
        b_snd = 0; b_cmd = '0; b_rx = 1; b_clr = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_a(16'hBEEF);
        for (int k = 0; k < 3; k++) run_a(16'($urandom));

        drive_rx(1'b0, 8'h77);
        repeat (40) @(negedge clk);
        chk("A_rx_discard_rrdy", a_rrdy, 1'b0);
        chk("A_rx_discard_resp", a_resp, 8'h00);

        run_b(32'h01234567, 0, 8'hA5, 1'b0);
        run_b($urandom, 1, 8'h5A, 1'b0);
        clr_b();
        run_b($urandom, 2, 8'h00, 1'b1);
        run_b($urandom, 0, 8'hA5, 1'b1);

        drive_rx(1'b1, 8'h3C);
        repeat (40) @(negedge clk);
        chk("B_rx_discard_resp", b_resp, exp_resp);
        chk("B_rx_discard_rrdy", b_rrdy, 1'b1);

        for (int k = 0; k < 5; k++) begin
            mode = $urandom_range(0, 2);
            rv = (mode == 0) ? 8'hA5 : 8'($urandom);
            run_b($urandom, mode, rv, 1'($urandom));
            if (mode != 2 && $urandom_range(0, 1) == 1) clr_b();
        end

        // Reset in the middle of the second byte aborts the transfer
        @(negedge clk); b_cmd = 32'hDEADBEEF; b_snd = 1'b1;
        @(negedge clk); b_snd = 1'b0;
        repeat (10 * D + 20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        exp_resp = 8'h00;
        @(negedge clk); rst_n = 1'b1;
        repeat (12 * D) @(negedge clk);
        chk("R_b_tx_idle", b_tx, 1'b1);
        run_b(32'hCAFEF00D, 0, 8'hA5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
